decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   RV32I instruction-decode stage. Takes the IF/ID instruction, drives register-file read addresses,
//   decodes controls and immediates, detects RAW hazards against EX/MEM, registers the ID/EX pipeline
//   register. Feeds the execute stage; WB-to-ID same-cycle bypass is handled inside the register file.
// PARAMETERS
//   XLEN       32             datapath width
//   NOP_INSTR  32'h0000_0013  encoding latched into ex_instr on bubbles (addi x0,x0,0)
// PORTS
//   clk            in   1     clock
//   rst            in   1     reset, synchronous, active-high
//   id_valid       in   1     IF/ID holds a valid instruction
//   id_instr       in   32    instruction word
//   id_pc          in   XLEN  PC of id_instr
//   rf_rs1/rf_rs2  out  5     register-file read addresses (combinational, = instr[19:15]/[24:20])
//   rf_rd1/rf_rd2  in   XLEN  register-file read data (combinational)
//   ex_busy_rd     in   5     rd of instruction currently in EX
//   ex_busy_we     in   1     EX instruction writes rd
//   mem_rd         in   5     rd of instruction in MEM
//   mem_we         in   1     MEM instruction writes rd
//   mem_wdata      in   XLEN  final MEM result (ALU or load data)
//   flush          in   1     branch/jump taken in EX: kill ID
//   hold           in   1     downstream stall: freeze ID/EX register
//   id_stall       out  1     combinational: IF/ID must hold its contents
//   ex_valid       out  1     ID/EX valid
//   ex_pc, ex_rs1_val, ex_rs2_val, ex_imm   out XLEN   latched PC, operands, sign-extended immediate
//   ex_rs1, ex_rs2, ex_rd                   out 5      latched register indices
//   ex_funct3 out 3; ex_funct7b5 out 1; ex_opclass out 4 (riscv_pkg::opclass_t)
//   ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal   out 1   controls; ex_illegal = unknown opcode
// BEHAVIOUR
//   - Reset: all ex_* = 0 except ex_instr-derived fields of NOP_INSTR; ex_valid=0; regs cleared.
//   - Latency 1 cycle ID->EX. id_stall, rf_rs* purely combinational.
//   - Source use: use_rs1 for all but LUI/AUIPC/JAL; use_rs2 only R/S/B. Unused or x0 source: never hazards.
//   - Immediates per I/S/B/U/J format, sign-extended to XLEN; R-type imm=0. ex_reg_we=0 when rd=x0.
//   - Illegal opcode: ex_illegal=1, ex_reg_we/ex_mem_*=0, ex_valid follows id_valid.
//   - hazard = id_valid & used src matches (ex_busy_rd & ex_busy_we) [or mem, see CONFIGURATION].
//   - Register update priority per cycle: rst > flush > hold > hazard > advance.
//       flush : ex_valid<=0, controls zeroed; id_stall=0 (IF refetches).
//       hold  : ID/EX unchanged; id_stall=1.
//       hazard: bubble (ex_valid<=0, ex_reg_we/mem_*<=0); id_stall=1.
//       advance: latch decoded instr; ex_valid<=id_valid.
//   - Bubble never writes registers or memory. flush in the same cycle as hold still bubbles.
//   - id_valid=0: no hazard, ex_valid<=0 on advance.
// CONFIGURATION
//   DECODE_MEM_BYPASS_EN defined: match on (mem_rd,mem_we) forwards mem_wdata into ex_rs*_val;
//     only EX match stalls; EX match has priority over MEM match.
//   Not defined: MEM match also stalls; operands come only from rf_rd*.
// STRUCTURE
//   riscv_pkg: opcode localparams (OP_LUI..OP_SYSTEM), opclass_t enum, imm-format enum, NOP constant.
//   Sub-module imm_gen (instr -> imm by format), purely combinational; rest inline.
// TESTING
//   1. rst=1 2 cycles, then addi x5,x0,7 (0x00700293) -> next cycle ex_valid=1, ex_imm=7, ex_rd=5, ex_reg_we=1.
//   2. ex_busy_rd=5,we=1, add x6,x5,x5 -> id_stall=1, ex_valid=0 next cycle; clear -> issues, no duplicate.
//   3. mem_rd=5,mem_we=1,mem_wdata=0xDEAD_BEEF, rf_rd1=0: with _EN ex_rs1_val=0xDEADBEEF, no stall;
//      without _EN 1-cycle stall.
//   4. beq with imm -4 (0xFE000EE3) -> ex_imm=0xFFFF_FFFC, ex_reg_we=0; lui x1,0x12345 -> ex_imm=0x1234_5000.
//   5. hold=1 and flush=1 same cycle with valid instr -> ex_valid=0, id_stall=0; hold alone freezes all ex_*.
//   6. addi x0,x0,1 and ex_busy_rd=0,we=1 -> no stall, ex_reg_we=0; opcode 0x7F -> ex_illegal=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, operation classes, immediate formats
// and the decoder for the control fields that go into the ID/EX register.
package decode_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // OC_NONE doubles as the class of an unrecognised opcode
    typedef enum logic [3:0] {
        OC_NONE   = 4'd0,
        OC_ALU_R  = 4'd1,
        OC_ALU_I  = 4'd2,
        OC_LOAD   = 4'd3,
        OC_STORE  = 4'd4,
        OC_BRANCH = 4'd5,
        OC_JAL    = 4'd6,
        OC_JALR   = 4'd7,
        OC_LUI    = 4'd8,
        OC_AUIPC  = 4'd9,
        OC_FENCE  = 4'd10,
        OC_SYSTEM = 4'd11
    } opclass_t;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_fmt_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        opclass_t    opclass;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } idex_ctrl_t;

    function automatic opclass_t opclass_of(input logic [6:0] opcode);
        case (opcode)
            OP_REG:    return OC_ALU_R;
            OP_IMM:    return OC_ALU_I;
            OP_LOAD:   return OC_LOAD;
            OP_STORE:  return OC_STORE;
            OP_BRANCH: return OC_BRANCH;
            OP_JAL:    return OC_JAL;
            OP_JALR:   return OC_JALR;
            OP_LUI:    return OC_LUI;
            OP_AUIPC:  return OC_AUIPC;
            OP_FENCE:  return OC_FENCE;
            OP_SYSTEM: return OC_SYSTEM;
            default:   return OC_NONE;
        endcase
    endfunction

    function automatic imm_fmt_t imm_fmt_of(input opclass_t oc);
        case (oc)
            OC_ALU_I, OC_LOAD, OC_JALR, OC_FENCE, OC_SYSTEM: return IMM_I;
            OC_STORE:           return IMM_S;
            OC_BRANCH:          return IMM_B;
            OC_LUI, OC_AUIPC:   return IMM_U;
            OC_JAL:             return IMM_J;
            default:            return IMM_R;
        endcase
    endfunction

    function automatic logic uses_rs1(input opclass_t oc);
        return !(oc == OC_LUI || oc == OC_AUIPC || oc == OC_JAL);
    endfunction

    function automatic logic uses_rs2(input opclass_t oc);
        return (oc == OC_ALU_R || oc == OC_STORE || oc == OC_BRANCH);
    endfunction

    function automatic idex_ctrl_t decode_ctrl(input logic [31:0] instr);
        idex_ctrl_t c;
        c          = '0;
        c.instr    = instr;
        c.rd       = instr[11:7];
        c.funct3   = instr[14:12];
        c.rs1      = instr[19:15];
        c.rs2      = instr[24:20];
        c.funct7b5 = instr[30];
        c.opclass  = opclass_of(instr[6:0]);
        c.illegal  = (c.opclass == OC_NONE);
        case (c.opclass)
            OC_ALU_R, OC_ALU_I, OC_LOAD, OC_JAL, OC_JALR, OC_LUI, OC_AUIPC: c.reg_we = 1'b1;
            // ECALL/EBREAK (funct3=0) write nothing; CSR ops write rd
            OC_SYSTEM: c.reg_we = (instr[14:12] != 3'b000);
            default:   c.reg_we = 1'b0;
        endcase
        if (c.rd == 5'd0) c.reg_we = 1'b0;
        c.mem_rd = (c.opclass == OC_LOAD);
        c.mem_wr = (c.opclass == OC_STORE);
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Signal bundle between the decode stage and its neighbours (IF/ID, regfile, EX/MEM).
// master = surrounding pipeline, slave = decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
    import decode_stage_pkg::*;

    logic            id_valid;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [4:0]      ex_busy_rd;
    logic            ex_busy_we;
    logic [4:0]      mem_rd;
    logic            mem_we;
    logic [XLEN-1:0] mem_wdata;
    logic            flush;
    logic            hold;
    logic            id_stall;
    logic            ex_valid;
    logic [31:0]     ex_instr;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    opclass_t        ex_opclass;
    logic            ex_reg_we;
    logic            ex_mem_rd;
    logic            ex_mem_wr;
    logic            ex_illegal;

    modport slave (
        input  id_valid, id_instr, id_pc, rf_rd1, rf_rd2,
        input  ex_busy_rd, ex_busy_we, mem_rd, mem_we, mem_wdata, flush, hold,
        output rf_rs1, rf_rs2, id_stall,
        output ex_valid, ex_instr, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_opclass,
        output ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal
    );

    modport master (
        output id_valid, id_instr, id_pc, rf_rd1, rf_rd2,
        output ex_busy_rd, ex_busy_we, mem_rd, mem_we, mem_wdata, flush, hold,
        input  rf_rs1, rf_rs2, id_stall,
        input  ex_valid, ex_instr, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_opclass,
        input  ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: selects the I/S/B/U/J bit layout and
// sign-extends to XLEN. R-type (and unknown) yields zero.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr_i,
    input  imm_fmt_t        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt_i)
            IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: regfile addressing, control/immediate decode, RAW hazard detection
// and the ID/EX register. Define DECODE_MEM_BYPASS_EN to forward MEM results instead of stalling.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);

    idex_ctrl_t      ctrl_dec;
    imm_fmt_t        fmt;
    logic [XLEN-1:0] imm;
    logic            use_rs1, use_rs2;
    logic            ex_m1, ex_m2, mem_m1, mem_m2;
    logic            hazard;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign ctrl_dec = decode_ctrl(bus.id_instr);
    assign fmt      = imm_fmt_of(ctrl_dec.opclass);
    assign use_rs1  = uses_rs1(ctrl_dec.opclass) && (ctrl_dec.rs1 != 5'd0);
    assign use_rs2  = uses_rs2(ctrl_dec.opclass) && (ctrl_dec.rs2 != 5'd0);

    assign bus.rf_rs1 = ctrl_dec.rs1;
    assign bus.rf_rs2 = ctrl_dec.rs2;

    decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (bus.id_instr[31:7]),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

    assign ex_m1  = use_rs1 && bus.ex_busy_we && (bus.ex_busy_rd == ctrl_dec.rs1);
    assign ex_m2  = use_rs2 && bus.ex_busy_we && (bus.ex_busy_rd == ctrl_dec.rs2);
    assign mem_m1 = use_rs1 && bus.mem_we && (bus.mem_rd == ctrl_dec.rs1);
    assign mem_m2 = use_rs2 && bus.mem_we && (bus.mem_rd == ctrl_dec.rs2);

`ifdef DECODE_MEM_BYPASS_EN
    assign hazard  = bus.id_valid && (ex_m1 || ex_m2);
    // An EX match stalls anyway; the guard keeps the EX-over-MEM priority explicit
    assign rs1_val = (mem_m1 && !ex_m1) ? bus.mem_wdata : bus.rf_rd1;
    assign rs2_val = (mem_m2 && !ex_m2) ? bus.mem_wdata : bus.rf_rd2;
`else
    assign hazard  = bus.id_valid && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
    assign rs1_val = bus.rf_rd1;
    assign rs2_val = bus.rf_rd2;
    logic unused_mem_wdata;
    assign unused_mem_wdata = ^bus.mem_wdata;
`endif

    // Flush overrides hold: the instruction in ID is dead, so IF must be free to refetch
    assign bus.id_stall = !bus.flush && (bus.hold || hazard);

    logic            valid_q, valid_d;
    idex_ctrl_t      ctrl_q, ctrl_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;
    logic [XLEN-1:0] imm_q, imm_d;

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        if (bus.flush || (!bus.hold && (hazard || !bus.id_valid))) begin
            valid_d   = 1'b0;
            ctrl_d    = decode_ctrl(NOP_INSTR);
            pc_d      = '0;
            rs1_val_d = '0;
            rs2_val_d = '0;
            imm_d     = '0;
        end else if (!bus.hold) begin
            valid_d   = 1'b1;
            ctrl_d    = ctrl_dec;
            pc_d      = bus.id_pc;
            rs1_val_d = rs1_val;
            rs2_val_d = rs2_val;
            imm_d     = imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= decode_ctrl(NOP_INSTR);
            pc_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_instr    = ctrl_q.instr;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1_val  = rs1_val_q;
    assign bus.ex_rs2_val  = rs2_val_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs1      = ctrl_q.rs1;
    assign bus.ex_rs2      = ctrl_q.rs2;
    assign bus.ex_rd       = ctrl_q.rd;
    assign bus.ex_funct3   = ctrl_q.funct3;
    assign bus.ex_funct7b5 = ctrl_q.funct7b5;
    assign bus.ex_opclass  = ctrl_q.opclass;
    assign bus.ex_reg_we   = ctrl_q.reg_we;
    assign bus.ex_mem_rd   = ctrl_q.mem_rd;
    assign bus.ex_mem_wr   = ctrl_q.mem_wr;
    assign bus.ex_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: expected ID/EX contents are queued as each instruction is
// presented and popped when the stage reports ex_valid.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e, got;
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t observe();
        exp_t o;
        o.pc      = bus.ex_pc;
        o.rd      = bus.ex_rd;
        o.imm     = bus.ex_imm;
        o.reg_we  = bus.ex_reg_we;
        o.mem_rd  = bus.ex_mem_rd;
        o.mem_wr  = bus.ex_mem_wr;
        o.illegal = bus.ex_illegal;
        o.rs1_val = bus.ex_rs1_val;
        o.rs2_val = bus.ex_rs2_val;
        return o;
    endfunction

    task automatic drive_idle();
        bus.id_valid   = 1'b0;
        bus.id_instr   = 32'h0000_0013;
        bus.id_pc      = '0;
        bus.rf_rd1     = '0;
        bus.rf_rd2     = '0;
        bus.ex_busy_rd = '0;
        bus.ex_busy_we = 1'b0;
        bus.mem_rd     = '0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = '0;
        bus.flush      = 1'b0;
        bus.hold       = 1'b0;
    endtask

    task automatic drive_instr(input logic [31:0] instr, input logic [31:0] pc);
        bus.id_valid = 1'b1;
        bus.id_instr = instr;
        bus.id_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b required 0", bus.ex_valid);
        end
        checks++;
        if (bus.ex_instr !== 32'h0000_0013 || bus.ex_opclass !== OC_ALU_I) begin
            errors++; $display("FAIL reset_nop: instr=%h opclass=%0d required 00000013/%0d",
                               bus.ex_instr, bus.ex_opclass, OC_ALU_I);
        end
        checks++;
        if (observe() !== '0) begin
            errors++; $display("FAIL reset_fields: got %h required 0", observe());
        end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        drive_idle();
        drive_instr(32'h0070_0293, 32'h100);
        #1;
        checks++;
        if ({bus.rf_rs1, bus.rf_rs2} !== {5'd0, 5'd7}) begin
            errors++; $display("FAIL addi_rf_addr: rs1=%0d rs2=%0d required 0/7", bus.rf_rs1, bus.rf_rs2);
        end
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL addi_stall: got %b required 0", bus.id_stall);
        end
        exp_q.push_back('{32'h100, 5'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL addi_issue: ex_valid=%b queued=%0d required 1", bus.ex_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL addi_fields: got %h required %h", got, e); end
        end
        bus.id_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL idle_valid: got %b required 0", bus.ex_valid);
        end
    endtask

    task automatic test_ex_hazard();
        drive_idle();
        bus.ex_busy_rd = 5'd5;
        bus.ex_busy_we = 1'b1;
        bus.rf_rd1     = 32'h11;
        bus.rf_rd2     = 32'h22;
        drive_instr(32'h0052_8333, 32'h104);
        #1;
        checks++;
        if (bus.id_stall !== 1'b1) begin
            errors++; $display("FAIL ex_haz_stall: got %b required 1", bus.id_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_we !== 1'b0) begin
            errors++; $display("FAIL ex_haz_bubble: valid=%b we=%b required 0/0", bus.ex_valid, bus.ex_reg_we);
        end
        bus.ex_busy_we = 1'b0;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL ex_haz_release: got %b required 0", bus.id_stall);
        end
        exp_q.push_back('{32'h104, 5'd6, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22});
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL ex_haz_issue: ex_valid=%b queued=%0d required 1", bus.ex_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL ex_haz_fields: got %h required %h", got, e); end
        end
        bus.id_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL ex_haz_dup: got ex_valid=%b required 0", bus.ex_valid);
        end
    endtask

    task automatic test_mem_match();
        drive_idle();
        bus.mem_rd    = 5'd5;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = 32'hDEAD_BEEF;
        drive_instr(32'h0012_8393, 32'h108);
        #1;
`ifdef DECODE_MEM_BYPASS_EN
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL mem_byp_stall: got %b required 0", bus.id_stall);
        end
`else
        checks++;
        if (bus.id_stall !== 1'b1) begin
            errors++; $display("FAIL mem_stall: got %b required 1", bus.id_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL mem_bubble: got ex_valid=%b required 0", bus.ex_valid);
        end
        bus.mem_we = 1'b0;
        bus.rf_rd1 = 32'hDEAD_BEEF;
        #1;
`endif
        exp_q.push_back('{32'h108, 5'd7, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0});
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL mem_issue: ex_valid=%b queued=%0d required 1", bus.ex_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL mem_fields: got %h required %h", got, e); end
        end
        bus.mem_we     = 1'b1;
        bus.ex_busy_rd = 5'd5;
        bus.ex_busy_we = 1'b1;
        drive_instr(32'h0012_8393, 32'h10C);
        #1;
        checks++;
        if (bus.id_stall !== 1'b1) begin
            errors++; $display("FAIL ex_over_mem_stall: got %b required 1", bus.id_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL ex_over_mem_bubble: got ex_valid=%b required 0", bus.ex_valid);
        end
        drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        drive_idle();
        bus.rf_rd1 = 32'h1000;
        bus.rf_rd2 = 32'hABCD;
        exp_q.push_back('{32'h200, 5'd29, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000, 32'hABCD});
        exp_q.push_back('{32'h204, 5'd8,  32'd8,         1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 32'hABCD});
        exp_q.push_back('{32'h208, 5'd3,  32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 32'hABCD});
        exp_q.push_back('{32'h20C, 5'd1,  32'd8,         1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'hABCD});
        exp_q.push_back('{32'h210, 5'd1,  32'h1234_5000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'hABCD});
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive_instr(32'hFE00_0EE3, 32'h200);
                1: drive_instr(32'h0020_A423, 32'h204);
                2: drive_instr(32'hFFC0_A183, 32'h208);
                3: drive_instr(32'h0080_00EF, 32'h20C);
                default: drive_instr(32'h1234_50B7, 32'h210);
            endcase
            @(posedge clk); #1;
            checks++;
            if (bus.ex_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL b2b_issue[%0d]: ex_valid=%b queued=%0d required 1", i, bus.ex_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front(); got = observe(); checks++;
                if (got !== e) begin errors++; $display("FAIL b2b_fields[%0d]: got %h required %h", i, got, e); end
            end
        end
    endtask

    task automatic test_hold_flush();
        bus.hold = 1'b1;
        drive_instr(32'h0090_0413, 32'h214);
        #1;
        checks++;
        if (bus.id_stall !== 1'b1) begin
            errors++; $display("FAIL hold_stall: got %b required 1", bus.id_stall);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_imm, bus.ex_reg_we} !==
            {1'b1, 32'h210, 5'd1, 32'h1234_5000, 1'b1}) begin
            errors++; $display("FAIL hold_freeze: valid=%b pc=%h rd=%0d imm=%h required 1/210/1/12345000",
                               bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_imm);
        end
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL flush_hold_stall: got %b required 0", bus.id_stall);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.ex_valid, bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr} !== 4'b0000) begin
            errors++; $display("FAIL flush_hold_bubble: got %b required 0000",
                               {bus.ex_valid, bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr});
        end
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        bus.rf_rd1 = '0;
        bus.rf_rd2 = '0;
        exp_q.push_back('{32'h214, 5'd8, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL hold_resume: ex_valid=%b queued=%0d required 1", bus.ex_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL hold_resume_fields: got %h required %h", got, e); end
        end
    endtask

    task automatic test_x0_illegal();
        drive_idle();
        bus.ex_busy_rd = 5'd0;
        bus.ex_busy_we = 1'b1;
        drive_instr(32'h0010_0013, 32'h300);
        #1;
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL x0_stall: got %b required 0", bus.id_stall);
        end
        exp_q.push_back('{32'h300, 5'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL x0_issue: ex_valid=%b queued=%0d required 1", bus.ex_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL x0_fields: got %h required %h", got, e); end
        end
        bus.ex_busy_we = 1'b0;
        drive_instr(32'h0000_007F, 32'h304);
        exp_q.push_back('{32'h304, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0});
        @(posedge clk); #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL illegal_issue: ex_valid=%b queued=%0d required 1", bus.ex_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL illegal_fields: got %h required %h", got, e); end
        end
        drive_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_ex_hazard();
        test_mem_match();
        test_back_to_back();
        test_hold_flush();
        test_x0_illegal();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
